multicycle_controller: RTL and testbench

- FSM sequencer for the multicycle RV32I core variant. A single ALU and a shared, variable-latency memory interface are time-shared across FETCH/DECODE/EXEC/MEM/WB phases.
- Replaces the single-cycle main decoder. It emits the same control set (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus PC and IR enables, stepped per phase.
- Supports R-type, I-type arithmetic, LW, SW and BEQ.

---
 rtl/riscv_ctrl_pkg.sv | 46 ++++
 rtl/opcode_class_dec.sv | 21 ++
 rtl/multicycle_controller.sv | 140 ++++++++++++++
 tb/tb_multicycle_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, phase and class definitions for the multicycle RV32I control path.
// ILLEGAL_TRAP_EN adds the TRAP phase.
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_ILL
    } class_e;

    function automatic logic [1:0] class_alu_op(input class_e c);
        case (c)
            CLS_R:   return ALUOP_R;
            CLS_I:   return ALUOP_I;
            CLS_BR:  return ALUOP_BR;
            default: return ALUOP_MEM;
        endcase
    endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode -> instruction class decode, shared with the hazard unit.
module opcode_class_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output class_e     op_class
);

    always_comb begin
        op_class = CLS_ILL;
        case (opcode)
            R_TYPE:  op_class = CLS_R;
            I_TYPE:  op_class = CLS_I;
            LW:      op_class = CLS_LD;
            SW:      op_class = CLS_ST;
            BR:      op_class = CLS_BR;
            default: op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I phase sequencer driving the shared ALU and memory ports.
// ILLEGAL_TRAP_EN: illegal opcodes park in TRAP with illegal_instr held high.
//
// state  | meaning
// FETCH  | request instruction word, load IR and bump PC when ready
// DECODE | classify opcode, latch class
// EXEC   | ALU operation; branches resolve here
// MEM    | data access, held until dmem_ready
// WB     | register file write
// TRAP   | illegal opcode seen, waits for reset (ILLEGAL_TRAP_EN only)
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_op,
`ifdef ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic       instr_done
);

    state_e state, state_nxt;
    class_e cls_q, dec_cls;

    opcode_class_dec u_dec (
        .opcode   (opcode),
        .op_class (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            cls_q <= CLS_NOP;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    // All outputs stay low while rst_n is low, regardless of the current phase.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = ALUOP_MEM;
        instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        if (rst_n) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    if (dec_cls == CLS_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        instr_done = 1'b1;
                        state_nxt  = FETCH;
`endif
                    end else begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    alu_op  = class_alu_op(cls_q);
                    alu_src = (cls_q == CLS_I) || (cls_q == CLS_LD) || (cls_q == CLS_ST);
                    case (cls_q)
                        CLS_BR: begin
                            branch     = 1'b1;
                            instr_done = 1'b1;
                            state_nxt  = FETCH;
                        end
                        CLS_R, CLS_I:   state_nxt = WB;
                        CLS_LD, CLS_ST: state_nxt = MEM;
                        default:        state_nxt = FETCH;
                    endcase
                end
                MEM: begin
                    alu_op    = ALUOP_MEM;
                    alu_src   = 1'b1;
                    mem_read  = (cls_q == CLS_LD);
                    mem_write = (cls_q == CLS_ST);
                    if (dmem_ready) begin
                        if (cls_q == CLS_LD) begin
                            state_nxt = WB;
                        end else begin
                            instr_done = 1'b1;
                            state_nxt  = FETCH;
                        end
                    end
                end
                WB: begin
                    alu_op     = class_alu_op(cls_q);
                    alu_src    = (cls_q == CLS_I) || (cls_q == CLS_LD);
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == CLS_LD);
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    illegal_instr = 1'b1;
                end
`endif
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; builds with or without ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready;
    logic       imem_req, ir_write, pc_write, branch, alu_src, mem_to_reg;
    logic       reg_write, mem_read, mem_write, instr_done;
    logic [1:0] alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b1110011;

    // {imem_req, ir_write, pc_write, branch, alu_src, mem_to_reg,
    //  reg_write, mem_read, mem_write, alu_op[1:0], instr_done}
    localparam logic [11:0] V_ZERO   = 12'h000;
    localparam logic [11:0] V_F_RDY  = 12'hE00;
    localparam logic [11:0] V_F_WAIT = 12'h800;
    localparam logic [11:0] V_DEC    = 12'h000;
    localparam logic [11:0] V_ILLNOP = 12'h001;
    localparam logic [11:0] V_EX_R   = 12'h004;
    localparam logic [11:0] V_WB_R   = 12'h025;
    localparam logic [11:0] V_EX_I   = 12'h086;
    localparam logic [11:0] V_WB_I   = 12'h0A7;
    localparam logic [11:0] V_EX_M   = 12'h080;
    localparam logic [11:0] V_MEM_LD = 12'h090;
    localparam logic [11:0] V_WB_LD  = 12'h0E1;
    localparam logic [11:0] V_MEM_ST = 12'h088;
    localparam logic [11:0] V_ST_DN  = 12'h089;
    localparam logic [11:0] V_EX_BR  = 12'h103;

    logic [11:0] outs;
    assign outs = {imem_req, ir_write, pc_write, branch, alu_src, mem_to_reg,
                   reg_write, mem_read, mem_write, alu_op, instr_done};

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %03h expected %03h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, check, then move to the next falling edge.
    task automatic cyc(input string tag, input logic ir, input logic dr,
                       input logic [6:0] op, input logic [11:0] exp);
        imem_ready = ir;
        dmem_ready = dr;
        opcode     = op;
        #1;
        chk(tag, outs, exp);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opcode = OP_R;
        @(negedge clk);
        cyc("rst0", 1, 1, OP_R, V_ZERO);
        rst_n = 1'b1;

        // ADD, ready tied high
        cyc("add_f",  1, 1, OP_R, V_F_RDY);
        cyc("add_d",  1, 1, OP_R, V_DEC);
        cyc("add_ex", 1, 1, OP_R, V_EX_R);
        cyc("add_wb", 1, 1, OP_R, V_WB_R);

        // ADDI
        cyc("addi_f",  1, 1, OP_I, V_F_RDY);
        cyc("addi_d",  1, 1, OP_I, V_DEC);
        cyc("addi_ex", 1, 1, OP_I, V_EX_I);
        cyc("addi_wb", 1, 1, OP_I, V_WB_I);

        // LW with three data wait cycles: 8 cycles total
        cyc("lw_f",  1, 0, OP_LW, V_F_RDY);
        cyc("lw_d",  1, 0, OP_LW, V_DEC);
        cyc("lw_ex", 1, 0, OP_LW, V_EX_M);
        for (int i = 0; i < 3; i++) cyc("lw_memwait", 1, 0, OP_LW, V_MEM_LD);
        cyc("lw_memrdy", 1, 1, OP_LW, V_MEM_LD);
        cyc("lw_wb",     1, 1, OP_LW, V_WB_LD);

        // SW then BEQ, zero wait
        cyc("sw_f",   1, 1, OP_SW, V_F_RDY);
        cyc("sw_d",   1, 1, OP_SW, V_DEC);
        cyc("sw_ex",  1, 1, OP_SW, V_EX_M);
        cyc("sw_mem", 1, 1, OP_SW, V_ST_DN);
        cyc("beq_f",  1, 1, OP_BEQ, V_F_RDY);
        cyc("beq_d",  1, 1, OP_BEQ, V_DEC);
        cyc("beq_ex", 1, 1, OP_BEQ, V_EX_BR);

        // Instruction fetch stall
        for (int i = 0; i < 5; i++) cyc("fetch_wait", 0, 1, OP_R, V_F_WAIT);
        cyc("fetch_rdy", 1, 1, OP_R, V_F_RDY);
        cyc("stall_d",   0, 1, OP_R, V_DEC);
        cyc("stall_ex",  0, 1, OP_R, V_EX_R);
        cyc("stall_wb",  0, 1, OP_R, V_WB_R);

        // Reset in the middle of a stalled store
        cyc("rsw_f",   1, 0, OP_SW, V_F_RDY);
        cyc("rsw_d",   1, 0, OP_SW, V_DEC);
        cyc("rsw_ex",  1, 0, OP_SW, V_EX_M);
        cyc("rsw_mem", 1, 0, OP_SW, V_MEM_ST);
        rst_n = 1'b0;
        cyc("rst_mid0", 1, 1, OP_SW, V_ZERO);
        cyc("rst_mid1", 1, 1, OP_SW, V_ZERO);
        rst_n = 1'b1;
        cyc("post_rst", 0, 1, OP_SW, V_F_WAIT);

        // Illegal opcode
        cyc("ill_f", 1, 0, OP_ILL, V_F_RDY);
`ifdef ILLEGAL_TRAP_EN
        cyc("ill_d", 1, 0, OP_ILL, V_DEC);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            opcode = OP_R;
            #1;
            chk("trap_outs", outs, V_ZERO);
            chk("trap_flag", {11'd0, illegal_instr}, 12'h001);
            @(negedge clk);
        end
        rst_n = 1'b0;
        cyc("trap_rst", 1, 1, OP_R, V_ZERO);
        rst_n = 1'b1;
        #1;
        chk("trap_clr", {11'd0, illegal_instr}, 12'h000);
        cyc("trap_fetch", 0, 0, OP_R, V_F_WAIT);
`else
        cyc("ill_d",     1, 0, OP_ILL, V_ILLNOP);
        cyc("ill_fetch", 0, 0, OP_ILL, V_F_WAIT);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
